// File: rtl/alu_exec_if.sv
// Operand/result bundle between the register file, the execute unit and its driver.
// master drives operands and Start; slave is the execute unit.
interface alu_exec_if #(
  parameter int WIDTH = 16
);
  logic             Start;
  logic [3:0]       OpCode;
  logic [WIDTH-1:0] RdestIn;
  logic [WIDTH-1:0] RsrcIn;
  logic [7:0]       Imm;
  logic             UseImm;
  logic [WIDTH-1:0] Result;
  logic             WrEn;
  logic             Done;
  logic             Busy;
  logic [4:0]       Flags;

  modport master (
    output Start, OpCode, RdestIn, RsrcIn, Imm, UseImm,
    input  Result, WrEn, Done, Busy, Flags
  );

  modport slave (
    input  Start, OpCode, RdestIn, RsrcIn, Imm, UseImm,
    output Result, WrEn, Done, Busy, Flags
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute stage: single-cycle ALU ops plus an iterative shift-add multiply.
// Flags = {C,L,F,Z,N}.
//
//   state  | meaning
//   IDLE   | accepting Start; single-cycle ops complete from here
//   MULT   | one shift-add step per edge until the step counter hits zero
module alu_exec_unit #(
  parameter int WIDTH     = 16,
  parameter int MUL_STEPS = 16
) (
  input logic        Clk,
  input logic        Rst,
  alu_exec_if.slave  bus
);
  localparam int CW  = $clog2(MUL_STEPS);
  localparam int SHW = $clog2(WIDTH);

  typedef enum logic {S_IDLE = 1'b0, S_MULT = 1'b1} state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] op_a, op_b, neg_b;
  logic [WIDTH:0]   sum_ext, dif_ext;
  logic             accept, is_mul;

  logic [WIDTH-1:0] mcand, mplier, acc, acc_nxt;
  logic [CW-1:0]    step_cnt;

  logic [WIDTH-1:0] result_q, alu_res;
  logic [4:0]       flags_q, alu_flags;
  logic             wr_q, done_q, alu_wr, busy_c;

  assign op_a    = bus.RdestIn;
  assign op_b    = bus.UseImm ? {{(WIDTH-8){bus.Imm[7]}}, bus.Imm} : bus.RsrcIn;
  assign neg_b   = -op_b;
  assign sum_ext = {1'b0, op_a} + {1'b0, op_b};
  assign dif_ext = {1'b0, op_a} - {1'b0, op_b};
  assign accept  = (state == S_IDLE) && bus.Start;
  assign is_mul  = (bus.OpCode == 4'd8);
  assign acc_nxt = acc + (mplier[0] ? mcand : '0);

  always_ff @(posedge Clk) begin
    if (Rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept && is_mul) state_nxt = S_MULT;
      S_MULT: if (step_cnt == '0)   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy_c    = (state == S_MULT);
    alu_res   = result_q;
    alu_flags = flags_q;
    alu_wr    = 1'b0;
    case (bus.OpCode)
      4'd0: begin
        alu_res      = sum_ext[WIDTH-1:0];
        alu_flags[4] = sum_ext[WIDTH];
        alu_flags[2] = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum_ext[WIDTH-1] != op_a[WIDTH-1]);
        alu_wr       = 1'b1;
      end
      4'd1: begin
        alu_res      = dif_ext[WIDTH-1:0];
        alu_flags[4] = dif_ext[WIDTH];
        alu_flags[2] = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (dif_ext[WIDTH-1] != op_a[WIDTH-1]);
        alu_wr       = 1'b1;
      end
      4'd2: begin
        alu_flags[1] = (op_a == op_b);
        alu_flags[3] = dif_ext[WIDTH];
        alu_flags[0] = ($signed(op_a) < $signed(op_b));
      end
      4'd3: begin alu_res = op_a & op_b; alu_wr = 1'b1; end
      4'd4: begin alu_res = op_a | op_b; alu_wr = 1'b1; end
      4'd5: begin alu_res = op_a ^ op_b; alu_wr = 1'b1; end
      4'd6: begin alu_res = op_b;        alu_wr = 1'b1; end
      4'd7: begin
        // signed shift amount: positive shifts left, negative shifts right
        if (!op_b[WIDTH-1] && (op_b[WIDTH-1:SHW] == '0))
          alu_res = op_a << op_b[SHW-1:0];
        else if (op_b[WIDTH-1] && (neg_b[WIDTH-1:SHW] == '0))
          alu_res = op_a >> neg_b[SHW-1:0];
        else
          alu_res = '0;
        alu_wr = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      result_q <= '0;
      flags_q  <= '0;
      wr_q     <= 1'b0;
      done_q   <= 1'b0;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      step_cnt <= '0;
    end else begin
      wr_q   <= 1'b0;
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (is_mul) begin
              mcand    <= op_a;
              mplier   <= op_b;
              acc      <= '0;
              step_cnt <= CW'(MUL_STEPS - 1);
            end else begin
              result_q <= alu_res;
              flags_q  <= alu_flags;
              wr_q     <= alu_wr;
              done_q   <= 1'b1;
            end
          end
        end
        S_MULT: begin
          acc      <= acc_nxt;
          mcand    <= mcand << 1;
          mplier   <= mplier >> 1;
          step_cnt <= step_cnt - 1'b1;
          if (step_cnt == '0) begin
            result_q <= acc_nxt;
            wr_q     <= 1'b1;
            done_q   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.Result = result_q;
  assign bus.Flags  = flags_q;
  assign bus.WrEn   = wr_q;
  assign bus.Done   = done_q;
  assign bus.Busy   = busy_c;
endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute stage directly downstream of the 16-entry register file.
- Consumes the RdestOut/RsrcOut operand pair and performs the ALU operation.
- Drives the writeback value (Result) and write strobe (WrEn), which connect to the register file's Load/En inputs, and holds the processor status flags.
- Single-cycle for logic/arithmetic ops; MUL is an iterative 16-step shift-add multiply with a Start/Busy/Done handshake.

Parameters:
- WIDTH, 16, datapath width; all arithmetic rules below are stated for 16.
- MUL_STEPS, 16, multiply iterations; must equal WIDTH.

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Rst  input  1  synchronous, active-high reset.
- Start  input  1  request; sampled only in IDLE.
- OpCode  input  4  0 ADD, 1 SUB, 2 CMP, 3 AND, 4 OR, 5 XOR, 6 MOV, 7 LSH, 8 MUL; 9-15 illegal.
- RdestIn  input  16  operand A, from register file RdestOut.
- RsrcIn  input  16  operand B source, from register file RsrcOut.
- Imm  input  8  immediate operand.
- UseImm  input  1  1: B = sign-extended Imm; 0: B = RsrcIn.
- Result  output  16  registered writeback data.
- WrEn  output  1  one-cycle writeback strobe.
- Done  output  1  one-cycle completion pulse.
- Busy  output  1  high while the multiply is in progress.
- Flags  output  5  registered PSR {C,L,F,Z,N}, bit 4 = C.

Behaviour:
- Reset (Rst=1 at an edge): state=IDLE; Result, Flags, step counter and multiply accumulators all 0; WrEn=Done=Busy=0.
- Rst takes priority over Start and aborts an in-flight MUL: no WrEn, no Done, Result unchanged from its reset value.
- States: IDLE and MULT.
- Operands A and B are captured at the accepting edge; later input changes have no effect on that operation.
- Single-cycle ops (OpCode 0-7): Start=1 in IDLE at edge n.
  - Result, Flags, Done=1 and WrEn are registered at that edge, so they are visible in the following cycle.
  - State stays IDLE; Busy stays 0.
  - WrEn=1 for every op except CMP.
- ADD: Result = A+B.
  - C = carry out of bit 15.
  - F = signed overflow (operands share a sign and the sum's sign differs).
  - L, Z, N unchanged.
- SUB: Result = A-B.
  - C = borrow (A<B unsigned).
  - F = signed overflow.
  - L, Z, N unchanged.
- CMP: no writeback.
  - Z = (A==B).
  - L = A<B unsigned.
  - N = A<B signed.
  - C, F unchanged.
- AND, OR, XOR, MOV (Result = B): flags unchanged.
- LSH: B is treated as a signed shift amount.
  - B in 0..15: A << B.
  - B in -15..-1: logical shift right by -B.
  - |B| > 15: Result = 0.
  - Flags unchanged.
- Illegal OpCode: Done=1, WrEn=0, Result and Flags unchanged.
- MUL: Start in IDLE at edge n captures A and B, clears the accumulator and counter, and moves to MULT.
  - One shift-add step per edge for 16 edges (n+1..n+16).
  - Busy=1 for cycles n+1..n+16.
  - At edge n+16: Result = low 16 bits of A*B (unsigned), Done=1, WrEn=1, return to IDLE.
  - Done is visible in cycle n+17; the upper product bits are discarded; flags unchanged.
- Start while in MULT is ignored; no queuing.
- Start in the cycle where Done=1 (state IDLE) is accepted, so back-to-back issue is allowed.
- Done and WrEn are exactly one cycle wide and deassert at the next edge unless a new single-cycle op completes there.
- Result holds its value between completions.

Test Plan:
- After reset: ADD, A=0x7FFF, RsrcIn=0x0001, UseImm=0 -> next cycle Result=0x8000, WrEn=1, Done=1, F=1, C=0; then ADD A=0xFFFF, B=0x0001 -> Result=0x0000, C=1, F=0.
- CMP A=0x0005, B=0x0005 -> Z=1, L=0, N=0, WrEn=0, Done=1; then CMP A=0x0001, B=0xFFFF -> Z=0, L=1, N=0, C/F unchanged.
- SUB, A=0x0003, UseImm=1, Imm=0xFF -> Result=0x0004, C=1; LSH A=0x8001, Imm=0xFF -> Result=0x4000; LSH Imm=0x10 -> Result=0x0000.
- MUL A=0x0123, B=0x0045 with Start at cycle 0 -> Busy=1 in cycles 1-16; Result=0x4E6F, Done=WrEn=1 only in cycle 17; Start=1 pulses during cycles 3-10 are ignored (no extra Done).
- MUL started, Rst=1 at cycle 8 -> next cycle Busy=0, Result=0, Flags=0, and no Done/WrEn ever fires for the aborted multiply.
- Back-to-back: AND 0xF0F0&0x0FF0 then Start XOR on the Done cycle -> Results 0x00F0, then A^B on consecutive cycles with two consecutive Done pulses; OpCode=0xC -> Done=1, WrEn=0, Result unchanged.
